// File: rtl/rx_pause_frame_ctl.sv
// Receive-side 802.3x PAUSE handler: parses RX bytes, loads pause quanta on a good frame, holds off TX.
// Optional: define CORETSE_PAUSE_UNICAST_DA_EN to also accept the station address as PAUSE DA.
module rx_pause_frame_ctl #(
  parameter logic [47:0] PAUSE_DA     = 48'h0180C2000001,
  parameter logic [15:0] CTRL_TYPE    = 16'h8808,
  parameter logic [15:0] PAUSE_OPCODE = 16'h0001
) (
  input  logic        CORETSE_AHBclk,
  input  logic        CORETSE_AHBrstn,
  input  logic        CORETSE_AHBclk_en,
  input  logic        CORETSE_AHBbyte_mode,
  input  logic        CORETSE_AHBpause_en,
  input  logic        CORETSE_AHBrx_dv,
  input  logic        CORETSE_AHBrx_sof,
  input  logic        CORETSE_AHBrx_eof,
  input  logic [7:0]  CORETSE_AHBrx_data,
  input  logic        CORETSE_AHBrx_fcs_ok,
  input  logic        CORETSE_AHBrx_err,
  output logic        CORETSE_AHBtx_pause,
  output logic        CORETSE_AHBpause_rcvd,
  output logic        CORETSE_AHBctrl_frame,
  output logic [15:0] CORETSE_AHBpause_timer
`ifdef CORETSE_PAUSE_UNICAST_DA_EN
  ,
  input  logic [47:0] CORETSE_AHBstation_addr
`endif
);

  typedef enum logic [1:0] {IDLE, HDR, MATCH, DISC} state_t;

  state_t      state_q, state_d, cur;
  logic        pen_s1_q, pen_q;
  logic [5:0]  cnt_q, cnt_d, idx;
  logic        mc_ok_q, mc_ok_d;
  logic        type_hi_q, type_hi_d, ctrl_ok_q, ctrl_ok_d;
  logic [15:0] quanta_q, quanta_d;
  logic [15:0] timer_q, timer_d;
  logic [6:0]  slot_q, slot_d;
  logic        pause_rcvd_q, ctrl_frame_q, ctrl_frame_d;
  logic        qual, mc_hit, uc_hit, hdr_bad, commit, slot_wrap;
`ifdef CORETSE_PAUSE_UNICAST_DA_EN
  logic        uc_ok_q, uc_ok_d;
`endif

  function automatic logic [7:0] da_byte(input logic [47:0] a, input logic [2:0] i);
    logic [7:0] r;
    r = a[7:0];
    if (i == 3'd0) r = a[47:40];
    else if (i == 3'd1) r = a[39:32];
    else if (i == 3'd2) r = a[31:24];
    else if (i == 3'd3) r = a[23:16];
    else if (i == 3'd4) r = a[15:8];
    return r;
  endfunction

  assign qual = CORETSE_AHBclk_en & CORETSE_AHBrx_dv;
  // sof forces byte 0 of a fresh header, whatever state the previous frame left behind
  assign cur  = CORETSE_AHBrx_sof ? HDR : state_q;
  assign idx  = CORETSE_AHBrx_sof ? 6'd0 : cnt_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mc_ok_d      = mc_ok_q;
    type_hi_d    = type_hi_q;
    ctrl_ok_d    = ctrl_ok_q;
    quanta_d     = quanta_q;
    ctrl_frame_d = 1'b0;
    commit       = 1'b0;
    hdr_bad      = 1'b0;
    mc_hit       = 1'b0;
    uc_hit       = 1'b0;
`ifdef CORETSE_PAUSE_UNICAST_DA_EN
    uc_ok_d      = uc_ok_q;
`endif
    if (qual) begin
      cnt_d = CORETSE_AHBrx_sof ? 6'd1 : ((cnt_q == 6'd63) ? 6'd63 : cnt_q + 6'd1);
      if (CORETSE_AHBrx_sof) begin
        type_hi_d = 1'b0;
        ctrl_ok_d = 1'b0;
      end
      if (cur != IDLE) begin
        if (idx == 6'd12) type_hi_d = (CORETSE_AHBrx_data == CTRL_TYPE[15:8]);
        if (idx == 6'd13) ctrl_ok_d = type_hi_q & (CORETSE_AHBrx_data == CTRL_TYPE[7:0]);
      end
      if (cur == HDR) begin
        if (idx < 6'd6) begin
          // track multicast and unicast DA candidates separately; fail only when both lose
          mc_hit = (CORETSE_AHBrx_sof | mc_ok_q) &
                   (CORETSE_AHBrx_data == da_byte(PAUSE_DA, idx[2:0]));
`ifdef CORETSE_PAUSE_UNICAST_DA_EN
          uc_hit = (CORETSE_AHBrx_sof | uc_ok_q) &
                   (CORETSE_AHBrx_data == da_byte(CORETSE_AHBstation_addr, idx[2:0]));
          uc_ok_d = uc_hit;
`endif
          mc_ok_d = mc_hit;
          hdr_bad = ~(mc_hit | uc_hit);
        end else if (idx == 6'd12) hdr_bad = (CORETSE_AHBrx_data != CTRL_TYPE[15:8]);
        else if (idx == 6'd13) hdr_bad = (CORETSE_AHBrx_data != CTRL_TYPE[7:0]);
        else if (idx == 6'd14) hdr_bad = (CORETSE_AHBrx_data != PAUSE_OPCODE[15:8]);
        else if (idx == 6'd15) hdr_bad = (CORETSE_AHBrx_data != PAUSE_OPCODE[7:0]);
        else if (idx == 6'd16) quanta_d[15:8] = CORETSE_AHBrx_data;
        else if (idx == 6'd17) quanta_d[7:0]  = CORETSE_AHBrx_data;
        state_d = hdr_bad ? DISC : ((idx == 6'd17) ? MATCH : HDR);
      end else begin
        state_d = cur;
      end
      if (CORETSE_AHBrx_eof && cur != IDLE) begin
        ctrl_frame_d = ctrl_ok_d;
        commit       = (state_d == MATCH) & CORETSE_AHBrx_fcs_ok & ~CORETSE_AHBrx_err & pen_q;
        state_d      = IDLE;
      end
    end
  end

  assign slot_wrap = CORETSE_AHBbyte_mode ? (slot_q == 7'd126) : (slot_q == 7'd127);

  always_comb begin
    timer_d = timer_q;
    slot_d  = slot_q;
    if (commit) begin
      timer_d = quanta_d;
      slot_d  = '0;
    end else if (!pen_q) begin
      timer_d = '0;
      slot_d  = '0;
    end else if (timer_q != 16'd0) begin
      if (CORETSE_AHBclk_en) begin
        slot_d = slot_q + (CORETSE_AHBbyte_mode ? 7'd2 : 7'd1);
        if (slot_wrap) timer_d = timer_q - 16'd1;
      end
    end else begin
      slot_d = '0;
    end
  end

  always_ff @(posedge CORETSE_AHBclk or negedge CORETSE_AHBrstn) begin
    if (!CORETSE_AHBrstn) begin
      state_q      <= IDLE;
      pen_s1_q     <= 1'b0;
      pen_q        <= 1'b0;
      cnt_q        <= '0;
      mc_ok_q      <= 1'b0;
      type_hi_q    <= 1'b0;
      ctrl_ok_q    <= 1'b0;
      quanta_q     <= '0;
      timer_q      <= '0;
      slot_q       <= '0;
      pause_rcvd_q <= 1'b0;
      ctrl_frame_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pen_s1_q     <= CORETSE_AHBpause_en;
      pen_q        <= pen_s1_q;
      cnt_q        <= cnt_d;
      mc_ok_q      <= mc_ok_d;
      type_hi_q    <= type_hi_d;
      ctrl_ok_q    <= ctrl_ok_d;
      quanta_q     <= quanta_d;
      timer_q      <= timer_d;
      slot_q       <= slot_d;
      pause_rcvd_q <= commit;
      ctrl_frame_q <= ctrl_frame_d;
    end
  end

`ifdef CORETSE_PAUSE_UNICAST_DA_EN
  always_ff @(posedge CORETSE_AHBclk or negedge CORETSE_AHBrstn) begin
    if (!CORETSE_AHBrstn) uc_ok_q <= 1'b0;
    else                  uc_ok_q <= uc_ok_d;
  end
`endif

  assign CORETSE_AHBtx_pause    = (timer_q != 16'd0);
  assign CORETSE_AHBpause_rcvd  = pause_rcvd_q;
  assign CORETSE_AHBctrl_frame  = ctrl_frame_q;
  assign CORETSE_AHBpause_timer = timer_q;

endmodule

// File: tb/tb_rx_pause_frame_ctl.sv
// Scoreboard bench for rx_pause_frame_ctl: frame events queued at stimulus, checked by a pulse monitor.
module tb_rx_pause_frame_ctl;

  logic        clk = 1'b0;
  logic        rstn, clk_en, byte_mode, pause_en;
  logic        rx_dv, rx_sof, rx_eof, rx_fcs_ok, rx_err;
  logic [7:0]  rx_data;
  logic        tx_pause, pause_rcvd, ctrl_frame;
  logic [15:0] pause_timer;
  logic        div2 = 1'b0;

  typedef struct packed {
    logic        ctrl;
    logic        rcvd;
    logic [15:0] timer;
  } ev_t;

  ev_t        exp_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] fbuf [0:59];

  rx_pause_frame_ctl dut (
    .CORETSE_AHBclk        (clk),
    .CORETSE_AHBrstn       (rstn),
    .CORETSE_AHBclk_en     (clk_en),
    .CORETSE_AHBbyte_mode  (byte_mode),
    .CORETSE_AHBpause_en   (pause_en),
    .CORETSE_AHBrx_dv      (rx_dv),
    .CORETSE_AHBrx_sof     (rx_sof),
    .CORETSE_AHBrx_eof     (rx_eof),
    .CORETSE_AHBrx_data    (rx_data),
    .CORETSE_AHBrx_fcs_ok  (rx_fcs_ok),
    .CORETSE_AHBrx_err     (rx_err),
    .CORETSE_AHBtx_pause   (tx_pause),
    .CORETSE_AHBpause_rcvd (pause_rcvd),
    .CORETSE_AHBctrl_frame (ctrl_frame),
    .CORETSE_AHBpause_timer(pause_timer)
  );

  always #5 clk = ~clk;

  initial begin
    clk_en = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      clk_en = div2 ? ~clk_en : 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: every pulse must correspond to the next queued frame event
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (pause_rcvd || ctrl_frame) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_pulse: got ctrl=%0b rcvd=%0b timer=%0h, expected no pulse",
                   ctrl_frame, pause_rcvd, pause_timer);
        end else begin
          e = exp_q.pop_front();
          chk("frame_event", {14'd0, ctrl_frame, pause_rcvd, pause_timer}, {14'd0, e});
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic build(input logic [47:0] da, input logic [15:0] ty,
                       input logic [15:0] op, input logic [15:0] q);
    logic [47:0] sa;
    sa = 48'h021122334455;
    for (int i = 0; i < 60; i++) fbuf[i] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      fbuf[i]     = da[47-8*i -: 8];
      fbuf[6 + i] = sa[47-8*i -: 8];
    end
    fbuf[12] = ty[15:8];
    fbuf[13] = ty[7:0];
    fbuf[14] = op[15:8];
    fbuf[15] = op[7:0];
    fbuf[16] = q[15:8];
    fbuf[17] = q[7:0];
  endtask

  // Sends bytes 0..len-1; stops before byte stop_at (leaving rx_dv asserted) when stop_at < len
  task automatic send(input int len, input logic fcs, input logic err, input int stop_at);
    for (int i = 0; i < len; i++) begin
      if (i == stop_at) return;
      rx_dv     = 1'b1;
      rx_sof    = (i == 0);
      rx_eof    = (i == len - 1);
      rx_data   = fbuf[i];
      rx_fcs_ok = (i == len - 1) ? fcs : 1'b0;
      rx_err    = (i == len - 1) ? err : 1'b0;
      do @(posedge clk); while (!clk_en);
      #1;
    end
    rx_dv = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0; rx_fcs_ok = 1'b0; rx_err = 1'b0;
  endtask

  task automatic good_pause(input logic [15:0] q);
    build(48'h0180C2000001, 16'h8808, 16'h0001, q);
    exp_q.push_back('{ctrl: 1'b1, rcvd: 1'b1, timer: q});
    send(60, 1'b1, 1'b0, 99);
  endtask

  task automatic no_commit(input logic [47:0] da, input logic [15:0] op, input int len,
                           input logic fcs, input logic err);
    build(da, 16'h8808, op, 16'h0040);
    exp_q.push_back('{ctrl: 1'b1, rcvd: 1'b0, timer: 16'h0000});
    send(len, fcs, err, 99);
    tick(3);
  endtask

  task automatic reset_outputs(input string tag);
    chk({tag, "_tx_pause"},   {31'd0, tx_pause},    32'd0);
    chk({tag, "_pause_rcvd"}, {31'd0, pause_rcvd},  32'd0);
    chk({tag, "_ctrl_frame"}, {31'd0, ctrl_frame},  32'd0);
    chk({tag, "_timer"},      {16'd0, pause_timer}, 32'd0);
  endtask

  initial begin
    int n;
    rstn = 1'b0; byte_mode = 1'b1; pause_en = 1'b1;
    rx_dv = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0; rx_data = 8'h00; rx_fcs_ok = 1'b0; rx_err = 1'b0;
    tick(3);
    reset_outputs("reset");
    rstn = 1'b1;
    tick(4);

    // GMII rate, quanta 3: 192 cycles of holdoff, timer stepping every 64 cycles
    good_pause(16'h0003);
    n = 0;
    while (tx_pause && n < 1000) begin
      if (n == 0)   chk("q3_timer_t0",   {16'd0, pause_timer}, 32'd3);
      if (n == 64)  chk("q3_timer_t64",  {16'd0, pause_timer}, 32'd2);
      if (n == 128) chk("q3_timer_t128", {16'd0, pause_timer}, 32'd1);
      tick(1);
      n++;
    end
    chk("q3_pause_cycles", n, 32'd192);
    chk("q3_timer_end", {16'd0, pause_timer}, 32'd0);
    tick(2);

    // rejected frames: ctrl_frame only, timer stays 0
    no_commit(48'h0180C2000001, 16'h0001, 60, 1'b0, 1'b0);
    no_commit(48'h0180C2000001, 16'h0001, 60, 1'b1, 1'b1);
    no_commit(48'h0180C2000001, 16'h0002, 60, 1'b1, 1'b0);
    no_commit(48'h0180C2000001, 16'h0001, 16, 1'b1, 1'b0);
    no_commit(48'h0180C2000002, 16'h0001, 60, 1'b1, 1'b0);
    pause_en = 1'b0;
    tick(4);
    no_commit(48'h0180C2000001, 16'h0001, 60, 1'b1, 1'b0);
    pause_en = 1'b1;
    tick(4);
    chk("rejects_timer", {16'd0, pause_timer}, 32'd0);

    // non-control EtherType: no pulse at all
    build(48'h0180C2000001, 16'h0800, 16'h0001, 16'h0010);
    send(60, 1'b1, 1'b0, 99);
    tick(3);
    chk("non_ctrl_timer", {16'd0, pause_timer}, 32'd0);

    // abandoned partial frame followed by sof restart
    build(48'h0180C2000001, 16'h8808, 16'h0001, 16'h0007);
    send(60, 1'b1, 1'b0, 10);
    good_pause(16'h0005);
    tick(3);

    // FFFF replaces the running count, then XON clears it
    good_pause(16'hFFFF);
    tick(5);
    good_pause(16'h0000);
    chk("xon_tx_pause", {31'd0, tx_pause}, 32'd0);
    tick(3);

    // pen drop while paused
    good_pause(16'd100);
    tick(10);
    pause_en = 1'b0;
    n = 0;
    while (tx_pause && n < 20) begin
      tick(1);
      n++;
    end
    chk("pen_drop_within3", {31'd0, (n <= 3)}, 32'd1);
    chk("pen_drop_timer", {16'd0, pause_timer}, 32'd0);
    pause_en = 1'b1;
    tick(4);

    // MII rate, enable every second cycle, quanta 1: 256 cycles of holdoff
    byte_mode = 1'b0;
    div2 = 1'b1;
    tick(2);
    good_pause(16'h0001);
    n = 0;
    while (tx_pause && n < 2000) begin
      tick(1);
      n++;
    end
    chk("mii_pause_cycles", n, 32'd256);
    div2 = 1'b0;
    byte_mode = 1'b1;
    tick(4);

    // async reset mid-frame while mid-pause
    good_pause(16'hFFFF);
    tick(20);
    build(48'h0180C2000001, 16'h8808, 16'h0001, 16'h0009);
    send(60, 1'b1, 1'b0, 8);
    #2;
    rstn = 1'b0;
    #1;
    reset_outputs("async_rst");
    rx_dv = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0;
    tick(2);
    rstn = 1'b1;
    tick(1);
    good_pause(16'h0002);
    n = 0;
    while (tx_pause && n < 1000) begin
      tick(1);
      n++;
    end
    chk("post_rst_pause_cycles", n, 32'd128);

    tick(5);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no completion, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/rx_pause_frame_ctl.md
Name: rx_pause_frame_ctl

Overview:
Receive-side IEEE 802.3x flow-control handler for the CoreTSE MAC. It is the far end of the transmit-side pause generator. The block parses the receive byte stream and recognises MAC-control PAUSE frames. On a good FCS it loads the received pause quanta into a slot-time timer and holds the local transmitter off until the timer expires. It sits between the RX framer (byte stream plus FCS status) and the TX MAC (holdoff input).

Parameters:
PAUSE_DA, 48'h0180C2000001, reserved multicast destination address accepted for PAUSE.
CTRL_TYPE, 16'h8808, MAC-control EtherType.
PAUSE_OPCODE, 16'h0001, PAUSE opcode.

Ports:
CORETSE_AHBclk  in  1  system clock
CORETSE_AHBrstn  in  1  reset, asynchronous, active-low
CORETSE_AHBclk_en  in  1  byte/nibble-rate enable; all state except the synchroniser advances only when high
CORETSE_AHBbyte_mode  in  1  1 = 8-bit (GMII) rate, 0 = 4-bit (MII) rate
CORETSE_AHBpause_en  in  1  pause-receive enable from register domain (asynchronous)
CORETSE_AHBrx_dv  in  1  rx_data valid
CORETSE_AHBrx_sof  in  1  first byte of frame, coincident with rx_dv
CORETSE_AHBrx_eof  in  1  last byte of frame, coincident with rx_dv
CORETSE_AHBrx_data  in  8  frame byte, DA first
CORETSE_AHBrx_fcs_ok  in  1  valid with rx_eof; 1 = FCS good
CORETSE_AHBrx_err  in  1  PHY error seen in current frame; sampled at rx_eof
CORETSE_AHBtx_pause  out  1  transmit holdoff
CORETSE_AHBpause_rcvd  out  1  one-cycle pulse when a PAUSE frame is committed
CORETSE_AHBctrl_frame  out  1  one-cycle pulse at frame end when EtherType == CTRL_TYPE (drives RX filter)
CORETSE_AHBpause_timer  out  16  remaining quanta

Behaviour:
- Reset: all outputs 0; FSM IDLE; byte count 0; slot count 0; timer 0; synchroniser flops 0.
- pause_en passes through a two-flop synchroniser. The synchronised value (pen) is 2 clocks late.
- A byte is qualified when clk_en & rx_dv. A 6-bit byte counter is cleared by sof, increments per qualified byte and saturates at 63.
- FSM states, each advancing only on a qualified byte:
  - IDLE -> HDR on sof (byte 0).
  - HDR compares bytes 0-5 to PAUSE_DA, 12-13 to CTRL_TYPE and 14-15 to PAUSE_OPCODE. Bytes 16-17 are captured into a quanta holding register (MSB first).
  - Any mismatch -> DISC. Byte 17 matched -> MATCH.
  - MATCH/DISC -> IDLE on eof.
  - sof in any state restarts HDR at byte 0; the partial frame is abandoned with no pulses.
- Frame end (qualified eof):
  - ctrl_frame pulses if bytes 12-13 matched CTRL_TYPE.
  - Commit occurs if state is MATCH (eof on byte 17 or later), fcs_ok=1, rx_err=0 and pen=1.
  - Runt frames (eof before byte 17) are never committed.
- Commit, registered, one cycle after the eof byte: timer <= quanta, slot <= 0, pause_rcvd pulses.
  - Quanta 0 clears the timer (XON).
  - A new commit replaces any running count.
- Timer:
  - While timer != 0 and clk_en, slot (7-bit) += 2 in byte_mode, += 1 otherwise.
  - Timer decrements when (byte_mode & slot==126) | (~byte_mode & slot==127). Slot wraps to 0 modulo 128.
  - One quanta = 512 bit times = 64 byte-clocks or 128 nibble-clocks.
  - While timer == 0, slot is held at 0.
- Commit and decrement in the same cycle: commit wins.
- pen falling: timer and slot clear on the next clock and tx_pause drops. Parsing continues and ctrl_frame still pulses.
- tx_pause = (timer != 0), taken from registers with no extra delay.
- Asynchronous reset mid-frame or mid-pause returns everything to reset values immediately.

Optional Feature:
CORETSE_PAUSE_UNICAST_DA_EN
- Defined: adds input CORETSE_AHBstation_addr[47:0]. Bytes 0-5 match if equal to PAUSE_DA or to station_addr.
- Undefined: only PAUSE_DA is accepted; the port is absent.

Test Plan:
- byte_mode=1, clk_en=1, pen=1, good PAUSE quanta 16'h0003 -> pause_rcvd 1 cycle after eof; tx_pause high exactly 192 cycles; timer reads 3, 2, 1, 0 at 64-cycle steps.
- byte_mode=0, clk_en every 2nd cycle, quanta 16'h0001 -> tx_pause high for 128 enabled clocks (256 cycles).
- Quanta 16'hFFFF running, second PAUSE with quanta 16'h0000 -> timer 0 and tx_pause low 1 cycle after the second eof.
- PAUSE with fcs_ok=0; PAUSE with rx_err=1; opcode 16'h0002; eof at byte 15 -> no pause_rcvd and timer unchanged in every case; ctrl_frame pulses for all four (type 8808 matched at bytes 12-13).
- Wrong DA 01-80-C2-00-00-02 -> DISC, no commit, ctrl_frame pulses. pen=0 with a good PAUSE frame -> no commit. Drop pen while timer=100 -> tx_pause low within 3 cycles.
- Assert rstn low mid-frame and mid-pause -> all outputs 0 immediately. Next good PAUSE frame after release commits normally.
